// File: rtl/mips_avalon_arbiter.sv
// mips_avalon_arbiter
// Two-master to one-slave Avalon-MM arbiter. Master 0 is instruction fetch and
// master 1 is data load/store. A registered grant FSM gives one master
// exclusive use of the shared memory slave for a whole transfer, while the
// other master is held off with waitrequest. Protocol misuse by either master
// sets a sticky error flag that only reset clears.

module mips_avalon_arbiter #(
   parameter int ROUND_ROBIN = 1,
   parameter int FIXED_PRIO  = 1
) (
   input  logic        clk,
   input  logic        reset,

   input  logic [31:0] m0_address,
   input  logic [3:0]  m0_byteenable,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,

   input  logic [31:0] m1_address,
   input  logic [3:0]  m1_byteenable,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,

   output logic [31:0] s_address,
   output logic [3:0]  s_byteenable,
   output logic        s_read,
   output logic        s_write,
   output logic [31:0] s_writedata,
   input  logic        s_waitrequest,
   input  logic [31:0] s_readdata,

   output logic [1:0]  grant,
   output logic        protocol_error
);

   // State encoding doubles as the one-hot grant vector.
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] OWN0 = 2'b01;
   localparam logic [1:0] OWN1 = 2'b10;

   localparam logic FIXED_BIT = (FIXED_PRIO != 0);
   localparam logic USE_RR    = (ROUND_ROBIN != 0);

   logic [1:0] state;
   logic [1:0] state_next;
   logic       last_winner;
   logic       last_winner_next;
   logic       m0_req;
   logic       m1_req;
   logic       rw_clash;
   logic       abandon;

   assign m0_req   = m0_read | m0_write;
   assign m1_req   = m1_read | m1_write;
   assign rw_clash = (m0_read & m0_write) | (m1_read & m1_write);
   assign grant    = state;

   // Picks the next owner from the current requests; on a tie round-robin
   // favours the master that did not win last, otherwise the fixed master.
   function automatic logic [1:0] arbitrate(input logic r0, input logic r1,
                                            input logic last);
      logic       tie_winner;
      logic [1:0] result;
      tie_winner = USE_RR ? ~last : FIXED_BIT;
      if (r0 && r1)
         result = tie_winner ? OWN1 : OWN0;
      else if (r0)
         result = OWN0;
      else if (r1)
         result = OWN1;
      else
         result = IDLE;
      return result;
   endfunction

   // Next-state logic: completions re-arbitrate on the same edge so
   // back-to-back grants need no idle bubble.
   always_comb begin
      state_next       = state;
      last_winner_next = last_winner;
      abandon          = 1'b0;
      case (state)
         IDLE: begin
            state_next = arbitrate(m0_req, m1_req, last_winner);
         end
         OWN0: begin
            if (m0_req && !s_waitrequest) begin
               last_winner_next = 1'b0;
               state_next       = arbitrate(m0_req, m1_req, 1'b0);
            end else if (!m0_req && s_waitrequest) begin
               state_next = IDLE;
               abandon    = 1'b1;
            end else if (!m0_req) begin
               state_next = arbitrate(1'b0, m1_req, last_winner);
            end
         end
         OWN1: begin
            if (m1_req && !s_waitrequest) begin
               last_winner_next = 1'b1;
               state_next       = arbitrate(m0_req, m1_req, 1'b1);
            end else if (!m1_req && s_waitrequest) begin
               state_next = IDLE;
               abandon    = 1'b1;
            end else if (!m1_req) begin
               state_next = arbitrate(m0_req, 1'b0, last_winner);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Grant state and round-robin history; reset makes FIXED_PRIO win the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last_winner <= ~FIXED_BIT;
      end else begin
         state       <= state_next;
         last_winner <= last_winner_next;
      end
   end

   // Sticky protocol error: abandoned transfers and simultaneous read+write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         protocol_error <= 1'b0;
      else if (abandon || rw_clash)
         protocol_error <= 1'b1;
   end

   // Datapath mux: the owner talks straight to the slave, everyone else is stalled.
   always_comb begin
      s_address      = 32'h0;
      s_byteenable   = 4'h0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_writedata    = 32'h0;
      m0_waitrequest = 1'b1;
      m0_readdata    = 32'h0;
      m1_waitrequest = 1'b1;
      m1_readdata    = 32'h0;
      case (state)
         OWN0: begin
            s_address      = m0_address;
            s_byteenable   = m0_byteenable;
            s_read         = m0_read;
            s_write        = m0_write & ~m0_read;
            s_writedata    = m0_writedata;
            m0_waitrequest = s_waitrequest;
            m0_readdata    = s_readdata;
         end
         OWN1: begin
            s_address      = m1_address;
            s_byteenable   = m1_byteenable;
            s_read         = m1_read;
            s_write        = m1_write & ~m1_read;
            s_writedata    = m1_writedata;
            m1_waitrequest = s_waitrequest;
            m1_readdata    = s_readdata;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Testbench for mips_avalon_arbiter: a vector table of per-cycle expectations
// plus hand-written multi-cycle sequences against a small memory slave model.
// A second instance runs with fixed priority to master 1.

module tb_mips_avalon_arbiter;

   logic        clk = 1'b0;
   logic        reset;

   logic [31:0] m0_address;
   logic [3:0]  m0_byteenable;
   logic        m0_read;
   logic        m0_write;
   logic [31:0] m0_writedata;
   logic        m0_waitrequest;
   logic [31:0] m0_readdata;

   logic [31:0] m1_address;
   logic [3:0]  m1_byteenable;
   logic        m1_read;
   logic        m1_write;
   logic [31:0] m1_writedata;
   logic        m1_waitrequest;
   logic [31:0] m1_readdata;

   logic [31:0] s_address;
   logic [3:0]  s_byteenable;
   logic        s_read;
   logic        s_write;
   logic [31:0] s_writedata;
   logic        s_waitrequest;
   logic [31:0] s_readdata;
   logic [1:0]  grant;
   logic        protocol_error;

   logic        fp_m0_waitrequest;
   logic [31:0] fp_m0_readdata;
   logic        fp_m1_waitrequest;
   logic [31:0] fp_m1_readdata;
   logic [31:0] fp_s_address;
   logic [3:0]  fp_s_byteenable;
   logic        fp_s_read;
   logic        fp_s_write;
   logic [31:0] fp_s_writedata;
   logic [1:0]  fp_grant;
   logic        fp_protocol_error;

   // Slave side: either a delayed memory model or values driven by the bench.
   logic        use_model;
   logic        tb_swait;
   logic [31:0] tb_rdata;
   int          slave_delay;
   int          wait_cnt;
   logic [31:0] mem [0:15];
   logic        model_wait;
   logic [3:0]  s_idx;

   int total = 0;
   int bad   = 0;

   mips_avalon_arbiter #(.ROUND_ROBIN(1), .FIXED_PRIO(1)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
      .s_write(s_write), .s_writedata(s_writedata),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .grant(grant), .protocol_error(protocol_error)
   );

   mips_avalon_arbiter #(.ROUND_ROBIN(0), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata),
      .m0_waitrequest(fp_m0_waitrequest), .m0_readdata(fp_m0_readdata),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata),
      .m1_waitrequest(fp_m1_waitrequest), .m1_readdata(fp_m1_readdata),
      .s_address(fp_s_address), .s_byteenable(fp_s_byteenable), .s_read(fp_s_read),
      .s_write(fp_s_write), .s_writedata(fp_s_writedata),
      .s_waitrequest(1'b0), .s_readdata(32'h0),
      .grant(fp_grant), .protocol_error(fp_protocol_error)
   );

   always #5 clk = ~clk;

   assign s_idx         = {s_address[13:12], s_address[3:2]};
   assign model_wait    = (s_read | s_write) && (wait_cnt < slave_delay);
   assign s_waitrequest = use_model ? model_wait : tb_swait;
   assign s_readdata    = use_model ? ((s_read && !model_wait) ? mem[s_idx] : 32'h0)
                                    : tb_rdata;

   // Slave model: counts wait cycles per transfer and commits writes on completion.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= 0;
         for (int i = 0; i < 16; i++) mem[i] <= 32'hA500_0000 + i;
      end else begin
         if ((s_read || s_write) && model_wait)
            wait_cnt <= wait_cnt + 1;
         else
            wait_cnt <= 0;
         if (use_model && s_write && !model_wait)
            for (int b = 0; b < 4; b++)
               if (s_byteenable[b]) mem[s_idx][8*b +: 8] <= s_writedata[8*b +: 8];
      end
   end

   // Vector record: {m0_rd,m0_wr,m1_rd,m1_wr,swait} in, {m0_wait,m1_wait,s_rd,s_wr,perr} out.
   typedef struct {
      logic [4:0] ins;
      logic [1:0] grant;
      logic [4:0] outs;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mk(input logic [4:0] ins, input logic [1:0] g,
                               input logic [4:0] outs);
      vec_t v;
      v.ins   = ins;
      v.grant = g;
      v.outs  = outs;
      return v;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input vec_t v, input logic [31:0] rdata);
      m0_read  = v.ins[4];
      m0_write = v.ins[3];
      m1_read  = v.ins[2];
      m1_write = v.ins[1];
      tb_swait = v.ins[0];
      tb_rdata = rdata;
   endtask

   task automatic clear_masters();
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      clear_masters();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_be;
      logic [31:0] rd;

      reset = 1'b1;
      clear_masters();
      use_model = 1'b0; tb_swait = 1'b0; tb_rdata = 32'h0; slave_delay = 0;
      m0_address = 32'h0000_0100; m0_writedata = 32'h1111_0000; m0_byteenable = 4'b0011;
      m1_address = 32'h0000_0200; m1_writedata = 32'h2222_0000; m1_byteenable = 4'b1100;

      // Reset values while reset is held.
      #2;
      check_output("rst grant", {30'h0, grant}, 32'h0);
      check_output("rst perr", {31'h0, protocol_error}, 32'h0);
      check_output("rst m0 wait", {31'h0, m0_waitrequest}, 32'h1);
      check_output("rst m1 wait", {31'h0, m1_waitrequest}, 32'h1);
      check_output("rst s_rd/wr", {30'h0, s_read, s_write}, 32'h0);

      vecs[0]  = mk(5'b00000, 2'b00, 5'b11000);
      vecs[1]  = mk(5'b10101, 2'b00, 5'b11000);
      vecs[2]  = mk(5'b10101, 2'b10, 5'b11100);
      vecs[3]  = mk(5'b10100, 2'b10, 5'b10100);
      vecs[4]  = mk(5'b10100, 2'b01, 5'b01100);
      vecs[5]  = mk(5'b00010, 2'b10, 5'b10010);
      vecs[6]  = mk(5'b00000, 2'b10, 5'b10000);
      vecs[7]  = mk(5'b01000, 2'b00, 5'b11000);
      vecs[8]  = mk(5'b01000, 2'b01, 5'b01010);
      vecs[9]  = mk(5'b00000, 2'b01, 5'b01000);
      vecs[10] = mk(5'b00111, 2'b00, 5'b11000);
      vecs[11] = mk(5'b00110, 2'b10, 5'b10101);
      vecs[12] = mk(5'b00000, 2'b10, 5'b10001);
      vecs[13] = mk(5'b00000, 2'b00, 5'b11001);

      do_reset();
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         rd = 32'h1234_0000 + i;
         apply_stimulus(vecs[i], rd);
         #1;
         exp_addr  = (vecs[i].grant == 2'b01) ? 32'h0000_0100 :
                     (vecs[i].grant == 2'b10) ? 32'h0000_0200 : 32'h0;
         exp_wdata = (vecs[i].grant == 2'b01) ? 32'h1111_0000 :
                     (vecs[i].grant == 2'b10) ? 32'h2222_0000 : 32'h0;
         exp_be    = (vecs[i].grant == 2'b01) ? 4'b0011 :
                     (vecs[i].grant == 2'b10) ? 4'b1100 : 4'b0000;
         check_output($sformatf("vec%0d grant", i), {30'h0, grant}, {30'h0, vecs[i].grant});
         check_output($sformatf("vec%0d m0_wait", i), {31'h0, m0_waitrequest}, {31'h0, vecs[i].outs[4]});
         check_output($sformatf("vec%0d m1_wait", i), {31'h0, m1_waitrequest}, {31'h0, vecs[i].outs[3]});
         check_output($sformatf("vec%0d s_read", i), {31'h0, s_read}, {31'h0, vecs[i].outs[2]});
         check_output($sformatf("vec%0d s_write", i), {31'h0, s_write}, {31'h0, vecs[i].outs[1]});
         check_output($sformatf("vec%0d perr", i), {31'h0, protocol_error}, {31'h0, vecs[i].outs[0]});
         check_output($sformatf("vec%0d s_addr", i), s_address, exp_addr);
         check_output($sformatf("vec%0d s_wdata", i), s_writedata, exp_wdata);
         check_output($sformatf("vec%0d s_be", i), {28'h0, s_byteenable}, {28'h0, exp_be});
         check_output($sformatf("vec%0d m0_rdata", i), m0_readdata,
                      (vecs[i].grant == 2'b01) ? rd : 32'h0);
         check_output($sformatf("vec%0d m1_rdata", i), m1_readdata,
                      (vecs[i].grant == 2'b10) ? rd : 32'h0);
      end

      // Reset in the middle of a stalled master 1 write.
      do_reset();
      use_model = 1'b1; slave_delay = 5;
      @(negedge clk);
      m1_address = 32'h0000_0010; m1_writedata = 32'h0BAD_F00D; m1_byteenable = 4'b1111;
      m1_write = 1'b1;
      #1;
      check_output("A grant idle", {30'h0, grant}, 32'h0);
      @(negedge clk); #1;
      check_output("A grant own1", {30'h0, grant}, 32'h2);
      check_output("A s_write", {31'h0, s_write}, 32'h1);
      check_output("A m1 wait", {31'h0, m1_waitrequest}, 32'h1);
      #1 reset = 1'b1;
      #1;
      check_output("A rst s_write", {31'h0, s_write}, 32'h0);
      check_output("A rst grant", {30'h0, grant}, 32'h0);
      check_output("A rst m1 wait", {31'h0, m1_waitrequest}, 32'h1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_output("A post m1 wait", {31'h0, m1_waitrequest}, 32'h1);
      @(negedge clk); #1;
      check_output("A regrant", {30'h0, grant}, 32'h2);

      // Lone master 0 read from the boot vector with a two-cycle slave.
      do_reset();
      use_model = 1'b1; slave_delay = 2;
      @(negedge clk);
      m0_address = 32'hBFC0_0000; m0_byteenable = 4'b1111; m0_read = 1'b1;
      #1;
      check_output("B latency grant", {30'h0, grant}, 32'h0);
      check_output("B latency s_read", {31'h0, s_read}, 32'h0);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk); #1;
         check_output($sformatf("B c%0d grant", c), {30'h0, grant}, 32'h1);
         check_output($sformatf("B c%0d m1 wait", c), {31'h0, m1_waitrequest}, 32'h1);
         check_output($sformatf("B c%0d m0 wait", c), {31'h0, m0_waitrequest}, (c < 3) ? 32'h1 : 32'h0);
      end
      check_output("B rdata", m0_readdata, 32'hA500_0000);
      @(negedge clk);
      m0_read = 1'b0;
      #1;
      check_output("B drop m1 wait", {31'h0, m1_waitrequest}, 32'h1);
      @(negedge clk); #1;
      check_output("B back idle", {30'h0, grant}, 32'h0);
      check_output("B perr", {31'h0, protocol_error}, 32'h0);

      // Simultaneous requests after reset: master 1 write first, then master 0 read.
      do_reset();
      use_model = 1'b1; slave_delay = 1;
      @(negedge clk);
      m0_address = 32'h0000_1000; m0_byteenable = 4'b1111; m0_read = 1'b1;
      m1_address = 32'h0000_1000; m1_byteenable = 4'b1111;
      m1_writedata = 32'hDEAD_BEEF; m1_write = 1'b1;
      #1;
      check_output("C idle", {30'h0, grant}, 32'h0);
      @(negedge clk); #1;
      check_output("C m1 first", {30'h0, grant}, 32'h2);
      check_output("C s_write", {31'h0, s_write}, 32'h1);
      check_output("C m1 wait hi", {31'h0, m1_waitrequest}, 32'h1);
      check_output("C m0 wait", {31'h0, m0_waitrequest}, 32'h1);
      @(negedge clk); #1;
      check_output("C m1 done", {31'h0, m1_waitrequest}, 32'h0);
      check_output("C s_wdata", s_writedata, 32'hDEAD_BEEF);
      @(negedge clk);
      m1_write = 1'b0;
      #1;
      check_output("C m0 no bubble", {30'h0, grant}, 32'h1);
      check_output("C s_read", {31'h0, s_read}, 32'h1);
      check_output("C m0 wait hi", {31'h0, m0_waitrequest}, 32'h1);
      @(negedge clk); #1;
      check_output("C m0 wait lo", {31'h0, m0_waitrequest}, 32'h0);
      check_output("C m0 rdata", m0_readdata, 32'hDEAD_BEEF);
      @(negedge clk);
      m0_read = 1'b0;
      #1;
      check_output("C mem word", mem[4'b0100], 32'hDEAD_BEEF);

      // Continuous requests from both masters: alternating versus fixed priority.
      do_reset();
      use_model = 1'b1; slave_delay = 0;
      @(negedge clk);
      m0_address = 32'h0000_0020; m1_address = 32'h0000_0024;
      m0_read = 1'b1; m1_read = 1'b1;
      #1;
      check_output("D idle", {30'h0, grant}, 32'h0);
      check_output("D fp idle", {30'h0, fp_grant}, 32'h0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); #1;
         check_output($sformatf("D rr xfer%0d", k), {30'h0, grant}, (k % 2 == 0) ? 32'h2 : 32'h1);
         check_output($sformatf("D fp xfer%0d", k), {30'h0, fp_grant}, 32'h2);
         check_output($sformatf("D fp m0 wait%0d", k), {31'h0, fp_m0_waitrequest}, 32'h1);
      end

      // Master 0 abandons a stalled read.
      do_reset();
      use_model = 1'b0; tb_swait = 1'b1; tb_rdata = 32'h0;
      @(negedge clk);
      m0_read = 1'b1;
      #1;
      check_output("E idle", {30'h0, grant}, 32'h0);
      @(negedge clk); #1;
      check_output("E own0", {30'h0, grant}, 32'h1);
      check_output("E m0 wait", {31'h0, m0_waitrequest}, 32'h1);
      @(negedge clk);
      m0_read = 1'b0;
      #1;
      check_output("E perr before", {31'h0, protocol_error}, 32'h0);
      @(negedge clk); #1;
      check_output("E to idle", {30'h0, grant}, 32'h0);
      check_output("E perr set", {31'h0, protocol_error}, 32'h1);
      repeat (3) @(negedge clk);
      #1;
      check_output("E perr sticky", {31'h0, protocol_error}, 32'h1);
      do_reset();
      #1;
      check_output("E perr cleared", {31'h0, protocol_error}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
